// File: rtl/aes_pkg.sv
`default_nettype none
// ============================================================================
// Module      : aes_pkg
// Description : Shared AES key-schedule types, SBOX table and helpers.
//               Optional feature macro: AES_KEYEXP_ZEROIZE_EN (adds ST_ZERO).
// Revision    : 1.0 - initial release
// ============================================================================
package aes_pkg;

    typedef enum logic [1:0] {
        KL_128 = 2'd0,
        KL_192 = 2'd1,
        KL_256 = 2'd2,
        KL_BAD = 2'd3
    } key_len_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_EXPAND = 2'd1,
        ST_DONE   = 2'd2
`ifdef AES_KEYEXP_ZEROIZE_EN
        ,
        ST_ZERO   = 2'd3
`endif
    } state_t;

    // Number of rounds indexed by key length in words (only 4, 6, 8 meaningful)
    localparam logic [3:0] NR_OF_NK [0:8] = '{
        4'd0, 4'd0, 4'd0, 4'd0, 4'd10, 4'd0, 4'd12, 4'd0, 4'd14
    };

    localparam logic [7:0] SBOX [0:255] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Key length in 32-bit words; zero for the illegal encoding
    function automatic logic [3:0] nk_of_len(input key_len_t kl);
        case (kl)
            KL_128:  return 4'd4;
            KL_192:  return 4'd6;
            KL_256:  return 4'd8;
            default: return 4'd0;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/aes_key_expander_seq_if.sv
`default_nettype none
// ============================================================================
// Module      : aes_key_expander_seq_if
// Description : Key load handshake, status and round-key read port bundle.
//               Optional feature macro: AES_KEYEXP_ZEROIZE_EN (adds zeroize).
// Revision    : 1.0 - initial release
// ============================================================================
interface aes_key_expander_seq_if #(
    parameter int MAX_NK = 8
);
    logic                  key_valid;
    logic                  key_ready;
    logic [1:0]            key_len;
    logic [0:32*MAX_NK-1]  key_in;
    logic                  busy;
    logic                  done;
    logic                  err;
    logic [3:0]            rounds_ready;
    logic [3:0]            rk_rd_idx;
    logic [0:127]          rk_rd_data;
`ifdef AES_KEYEXP_ZEROIZE_EN
    logic                  zeroize;

    modport slave (
        input  key_valid, key_len, key_in, rk_rd_idx, zeroize,
        output key_ready, busy, done, err, rounds_ready, rk_rd_data
    );
    modport master (
        output key_valid, key_len, key_in, rk_rd_idx, zeroize,
        input  key_ready, busy, done, err, rounds_ready, rk_rd_data
    );
`else
    modport slave (
        input  key_valid, key_len, key_in, rk_rd_idx,
        output key_ready, busy, done, err, rounds_ready, rk_rd_data
    );
    modport master (
        output key_valid, key_len, key_in, rk_rd_idx,
        input  key_ready, busy, done, err, rounds_ready, rk_rd_data
    );
`endif
endinterface
`default_nettype wire

// File: rtl/aes_sbox_word.sv
`default_nettype none
// ============================================================================
// Module      : aes_sbox_word
// Description : Combinational AES SubWord, four parallel SBOX lookups.
// Revision    : 1.0 - initial release
// ============================================================================
module aes_sbox_word
    import aes_pkg::*;
(
    input  wire logic [31:0] i_word,
    output logic      [31:0] o_word
);
    assign o_word = {SBOX[i_word[31:24]], SBOX[i_word[23:16]],
                     SBOX[i_word[15:8]],  SBOX[i_word[7:0]]};
endmodule
`default_nettype wire

// File: rtl/aes_key_expander_seq.sv
`default_nettype none
// ============================================================================
// Module      : aes_key_expander_seq
// Description : Sequential AES-128/192/256 key expansion, one word per clock,
//               with a registered 128-bit round-key read port.
//               Optional feature macro: AES_KEYEXP_ZEROIZE_EN (store wipe).
// Revision    : 1.0 - initial release
// ============================================================================
module aes_key_expander_seq
    import aes_pkg::*;
#(
    parameter int MAX_NK = 8
)
(
    input  wire logic            clk,
    input  wire logic            reset,
    aes_key_expander_seq_if.slave bus
);
    localparam int MAX_WORDS = 4 * (MAX_NK + 7);
    localparam int c_AW      = 6;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [31:0]      r_store [0:MAX_WORDS-1];
    logic [c_AW-1:0]  r_idx;
    logic [c_AW-1:0]  r_last_idx;
    logic [3:0]       r_nk;
    logic [3:0]       r_wrap;
    logic [3:0]       r_rounds;
    logic [7:0]       r_rcon;
    logic             r_err;
    logic [0:127]     r_rd_data;

    key_len_t         w_len;
    logic [3:0]       w_nk_in;
    logic             w_legal;
    logic             w_zero_req;
    logic             w_key_ready, w_busy, w_done;
    logic             w_accept, w_accept_bad, w_step, w_zero_start, w_zero_step;

    assign w_len   = key_len_t'(bus.key_len);
    assign w_nk_in = nk_of_len(w_len);
    assign w_legal = (w_len != KL_BAD) && (int'(w_nk_in) <= MAX_NK);
`ifdef AES_KEYEXP_ZEROIZE_EN
    assign w_zero_req = bus.zeroize;
`else
    assign w_zero_req = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_key_ready  = 1'b0;
        w_busy       = 1'b0;
        w_done       = 1'b0;
        w_accept     = 1'b0;
        w_accept_bad = 1'b0;
        w_step       = 1'b0;
        w_zero_start = 1'b0;
        w_zero_step  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_key_ready = 1'b1;
                if (w_zero_req) begin
                    w_zero_start = 1'b1;
`ifdef AES_KEYEXP_ZEROIZE_EN
                    w_state_nxt  = ST_ZERO;
`endif
                end else if (bus.key_valid) begin
                    if (w_legal) begin
                        w_accept    = 1'b1;
                        w_state_nxt = ST_EXPAND;
                    end else begin
                        w_accept_bad = 1'b1;
                    end
                end
            end
            ST_EXPAND: begin
                w_busy = 1'b1;
                w_step = 1'b1;
                if (r_idx == r_last_idx) w_state_nxt = ST_DONE;
            end
            ST_DONE: begin
                w_done      = 1'b1;
                w_state_nxt = ST_IDLE;
            end
`ifdef AES_KEYEXP_ZEROIZE_EN
            ST_ZERO: begin
                w_busy      = 1'b1;
                w_zero_step = 1'b1;
                if (int'(r_idx) == MAX_WORDS - 1) w_state_nxt = ST_DONE;
            end
`endif
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Schedule datapath: t derived from w[i-1], combined with w[i-Nk]
    logic [c_AW-1:0] w_nk_aw;
    logic [31:0]     w_prev, w_back, w_sub_in, w_sub_out, w_t, w_new;

    assign w_nk_aw  = {{(c_AW-4){1'b0}}, r_nk};
    assign w_prev   = r_store[r_idx - 1'b1];
    assign w_back   = r_store[r_idx - w_nk_aw];
    assign w_sub_in = (r_wrap == 4'd0) ? {w_prev[23:0], w_prev[31:24]} : w_prev;

    aes_sbox_word u_sbox (
        .i_word (w_sub_in),
        .o_word (w_sub_out)
    );

    always_comb begin
        w_t = w_prev;
        if (r_wrap == 4'd0)
            w_t = w_sub_out ^ {r_rcon, 24'h0};
        else if (r_nk == 4'd8 && r_wrap == 4'd4)
            w_t = w_sub_out;
    end
    assign w_new = w_back ^ w_t;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_idx      <= '0;
            r_last_idx <= '0;
            r_nk       <= 4'd4;
            r_wrap     <= 4'd0;
            r_rcon     <= 8'h01;
            r_rounds   <= 4'd0;
            r_err      <= 1'b0;
        end else begin
            r_err <= w_accept_bad;
            if (w_accept) begin
                r_nk       <= w_nk_in;
                r_idx      <= {{(c_AW-4){1'b0}}, w_nk_in};
                r_last_idx <= {NR_OF_NK[w_nk_in], 2'b11};
                r_wrap     <= 4'd0;
                r_rcon     <= 8'h01;
                r_rounds   <= w_nk_in >> 2;
            end else if (w_step) begin
                r_idx  <= r_idx + 1'b1;
                r_wrap <= (r_wrap == r_nk - 4'd1) ? 4'd0 : r_wrap + 4'd1;
                if (r_wrap == 4'd0)     r_rcon   <= xtime(r_rcon);
                if (r_idx[1:0] == 2'd3) r_rounds <= r_rounds + 4'd1;
            end else if (w_zero_start) begin
                r_idx    <= '0;
                r_rounds <= 4'd0;
            end else if (w_zero_step) begin
                r_idx <= r_idx + 1'b1;
            end
        end
    end

    // Store has no reset; writes are suppressed on a reset edge so an abort is immediate
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (w_accept) begin
                for (int j = 0; j < MAX_NK; j++) begin
                    if (j < int'(w_nk_in)) r_store[j] <= bus.key_in[32*j +: 32];
                end
            end
            if (w_step)      r_store[r_idx] <= w_new;
            if (w_zero_step) r_store[r_idx] <= 32'h0;
        end
    end

    logic [c_AW-1:0] w_rd_base;
    logic [0:127]    w_rd_line;
    assign w_rd_base = {bus.rk_rd_idx, 2'b00};

    for (genvar k = 0; k < 4; k++) begin : g_rd_word
        logic [c_AW-1:0] w_addr;
        assign w_addr = w_rd_base | c_AW'(k);
        assign w_rd_line[32*k +: 32] = (int'(w_addr) < MAX_WORDS) ? r_store[w_addr] : 32'h0;
    end

    always_ff @(posedge clk) begin
        if (reset) r_rd_data <= '0;
        else       r_rd_data <= w_rd_line;
    end

    assign bus.key_ready    = w_key_ready;
    assign bus.busy         = w_busy;
    assign bus.done         = w_done;
    assign bus.err          = r_err;
    assign bus.rounds_ready = r_rounds;
    assign bus.rk_rd_data   = r_rd_data;

endmodule
`default_nettype wire

// File: tb/tb_aes_key_expander_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_aes_key_expander_seq
// Description : Self-checking bench for aes_key_expander_seq against an
//               algebraic key-schedule model (SBOX built from GF(2^8)).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_aes_key_expander_seq;
    localparam int MAX_NK    = 8;
    localparam int MAX_WORDS = 4 * (MAX_NK + 7);

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    aes_key_expander_seq_if #(.MAX_NK(MAX_NK)) bus ();

    aes_key_expander_seq #(.MAX_NK(MAX_NK)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int          n_checks = 0;
    int          n_errors = 0;
    logic [7:0]  sb [256];
    logic [31:0] mw [64];

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // SBOX = affine transform of the multiplicative inverse in GF(2^8)
    task automatic build_sbox();
        for (int v = 0; v < 256; v++) begin
            logic [7:0] b, inv;
            b   = v[7:0];
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (b != 8'h00 && gmul(b, y[7:0]) == 8'h01) inv = y[7:0];
            sb[v] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                        ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
        end
    endtask

    function automatic logic [31:0] sub_word(input logic [31:0] x);
        return {sb[x[31:24]], sb[x[23:16]], sb[x[15:8]], sb[x[7:0]]};
    endfunction

    function automatic logic [7:0] rcon_of(input int k);
        logic [7:0] r = 8'h01;
        for (int j = 1; j < k; j++) r = gmul(r, 8'h02);
        return r;
    endfunction

    task automatic model(input logic [0:255] key, input int nk);
        logic [31:0] t;
        for (int i = 0; i < nk; i++) mw[i] = key[32*i +: 32];
        for (int i = nk; i < 4 * (nk + 7); i++) begin
            t = mw[i-1];
            if (i % nk == 0)
                t = sub_word({t[23:0], t[31:24]}) ^ {rcon_of(i / nk), 24'h0};
            else if (nk == 8 && i % 8 == 4)
                t = sub_word(t);
            mw[i] = mw[i-nk] ^ t;
        end
    endtask

    function automatic logic [127:0] model_round(input int r);
        return {mw[4*r], mw[4*r+1], mw[4*r+2], mw[4*r+3]};
    endfunction

    function automatic logic [0:255] rand_key();
        return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic run_key(input logic [0:255] key, input int len, input bit poke, input bit early);
        int nk, nr, cnt, rr, idx;
        bit seen_done, pend, early_done;
        logic [127:0] pend_exp;
        string ptag;
        nk = (len == 0) ? 4 : (len == 1) ? 6 : 8;
        nr = nk + 6;
        model(key, nk);
        cnt = 0;
        while (!bus.key_ready && cnt < 100) begin @(negedge clk); cnt++; end
        check("ready_before_accept", bus.key_ready, 1);
        bus.key_valid = 1'b1;
        bus.key_len   = len[1:0];
        bus.key_in    = key;
        @(negedge clk);
        check("busy_after_accept", bus.busy, 1);
        check("ready_low_after_accept", bus.key_ready, 0);
        check("rr_after_accept", bus.rounds_ready, nk / 4);
        bus.key_valid = poke;
        bus.key_in    = rand_key();
        bus.key_len   = 2'($urandom_range(3, 0));
        cnt = 1; seen_done = 0; pend = 0; early_done = 0;
        pend_exp = '0; ptag = "";
        while (!seen_done && cnt < 100) begin
            if (pend) check(ptag, bus.rk_rd_data, pend_exp);
            pend = 0;
            if (bus.done) begin
                seen_done = 1;
            end else begin
                check("err_quiet", bus.err, 0);
                rr = int'(bus.rounds_ready);
                if (early && !early_done && rr >= 2) begin
                    idx = 1; early_done = 1; ptag = "early_rk1";
                    pend_exp = 128'ha0fafe1788542cb123a339392a6c7605;
                end else begin
                    idx = (rr > 0) ? int'($urandom_range(rr - 1, 0)) : 0;
                    ptag = "rk_during_expand";
                    pend_exp = model_round(idx);
                end
                bus.rk_rd_idx = idx[3:0];
                pend = 1;
                if (poke) bus.key_in = rand_key();
                @(negedge clk);
                cnt++;
            end
        end
        bus.key_valid = 1'b0;
        check("done_seen", seen_done, 1);
        check("done_latency", cnt, 4 * (nk + 7) - nk + 1);
        check("busy_low_at_done", bus.busy, 0);
        check("ready_low_at_done", bus.key_ready, 0);
        check("rr_final", bus.rounds_ready, nr + 1);
        if (early) check("early_read_taken", early_done, 1);
        @(negedge clk);
        check("done_pulse_end", bus.done, 0);
        check("ready_after_done", bus.key_ready, 1);
        for (int r = 0; r <= nr; r++) begin
            bus.rk_rd_idx = r[3:0];
            @(negedge clk);
            check("rk_final", bus.rk_rd_data, model_round(r));
        end
    endtask

    task automatic read_round(input int r, output logic [127:0] d);
        bus.rk_rd_idx = r[3:0];
        @(negedge clk);
        d = bus.rk_rd_data;
    endtask

    initial begin
        logic [0:255]  k;
        logic [127:0]  d;
        int            rr0, cnt;
        build_sbox();
        reset         = 1'b1;
        bus.key_valid = 1'b0;
        bus.key_len   = 2'd0;
        bus.key_in    = '0;
        bus.rk_rd_idx = 4'd0;
`ifdef AES_KEYEXP_ZEROIZE_EN
        bus.zeroize   = 1'b0;
`endif
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check("rst_key_ready", bus.key_ready, 1);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_err", bus.err, 0);
        check("rst_rounds", bus.rounds_ready, 0);
        check("rst_rd_data", bus.rk_rd_data, 0);

        k = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
        run_key(k, 0, 1'b0, 1'b1);
        read_round(10, d);
        check("aes128_round10", d, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

        rr0 = int'(bus.rounds_ready);
        bus.key_valid = 1'b1;
        bus.key_len   = 2'd3;
        bus.key_in    = rand_key();
        @(negedge clk);
        bus.key_valid = 1'b0;
        check("err_pulse", bus.err, 1);
        check("err_rounds_kept", bus.rounds_ready, rr0);
        check("err_stays_idle", bus.key_ready, 1);
        check("err_not_busy", bus.busy, 0);
        @(negedge clk);
        check("err_pulse_end", bus.err, 0);
        read_round(10, d);
        check("store_after_err", d, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

        k = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
        run_key(k, 1, 1'b1, 1'b0);
        read_round(12, d);
        check("aes192_w51", d[31:0], 32'h01002202);

        k = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
        run_key(k, 2, 1'b0, 1'b0);
        read_round(14, d);
        check("aes256_w59", d[31:0], 32'h706c631e);

`ifdef AES_KEYEXP_ZEROIZE_EN
        bus.zeroize   = 1'b1;
        bus.key_valid = 1'b1;
        bus.key_len   = 2'd0;
        @(negedge clk);
        bus.zeroize   = 1'b0;
        bus.key_valid = 1'b0;
        check("zero_busy", bus.busy, 1);
        check("zero_rounds", bus.rounds_ready, 0);
        cnt = 1;
        while (bus.busy && cnt < 200) begin @(negedge clk); cnt++; end
        check("zero_busy_cycles", cnt - 1, MAX_WORDS);
        check("zero_done", bus.done, 1);
        @(negedge clk);
        for (int r = 0; r <= 14; r++) begin
            read_round(r, d);
            check("zero_round", d, 0);
        end
`endif

        // Abort in the middle of an expansion
        k = rand_key();
        bus.key_valid = 1'b1;
        bus.key_len   = 2'd0;
        bus.key_in    = k;
        @(negedge clk);
        bus.key_valid = 1'b0;
        repeat (19) @(negedge clk);
        check("mid_busy", bus.busy, 1);
        reset = 1'b1;
        @(negedge clk);
        check("abort_rounds", bus.rounds_ready, 0);
        check("abort_key_ready", bus.key_ready, 1);
        check("abort_busy", bus.busy, 0);
        check("abort_rd_data", bus.rk_rd_data, 0);
        reset = 1'b0;
        @(negedge clk);
        check("abort_idle_hold", bus.key_ready, 1);

        for (int n = 0; n < 6; n++)
            run_key(rand_key(), int'($urandom_range(2, 0)), 1'($urandom_range(1, 0)), 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
